bram_port_arbiter: RTL and testbench

- Multi-channel front end for a single Block RAM port.
- N_CHAN requesters issue byte-addressed read/write requests over a req/gnt handshake.
- The block arbitrates round-robin, drives one registered BRAM master port, and routes read data back to the issuing channel.
- It tracks channel ownership through a tag pipeline sized for a configurable BRAM read latency.
- It sits between RAB-side table/config logic and one BRAM port.

---
 rtl/bram_port_arbiter.sv | 110 +++++++++++
 tb/tb_bram_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin front end that shares one registered BRAM port among N_CHAN requesters
// and steers read data back to the issuing channel via a fixed-latency tag pipeline.
module bram_port_arbiter #(
  parameter int N_CHAN     = 4,
  parameter int DATA_BITW  = 32,
  parameter int ADDR_BITW  = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                            Clk_CI,
  input  logic                            Rst_RBI,
  input  logic [N_CHAN-1:0]               Req_SI,
  output logic [N_CHAN-1:0]               Gnt_SO,
  input  logic [N_CHAN*ADDR_BITW-1:0]     Addr_DI,
  input  logic [N_CHAN*DATA_BITW/8-1:0]   WrEn_SI,
  input  logic [N_CHAN*DATA_BITW-1:0]     Wr_DI,
  output logic [N_CHAN-1:0]               RdValid_SO,
  output logic [DATA_BITW-1:0]            Rd_DO,
  output logic                            Bram_En_SO,
  output logic [ADDR_BITW-1:0]            Bram_Addr_SO,
  output logic [DATA_BITW-1:0]            Bram_Wr_DO,
  output logic [DATA_BITW/8-1:0]          Bram_WrEn_SO,
  input  logic [DATA_BITW-1:0]            Bram_Rd_DI
);
  localparam int BE_W   = DATA_BITW / 8;
  localparam int IDX_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int STAGES = RD_LATENCY;

  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     c_idx, sel;
  logic [N_CHAN-1:0]    gnt;
  logic                 acc;
  logic [ADDR_BITW-1:0] addr_sel;
  logic [BE_W-1:0]      be_sel;
  logic [DATA_BITW-1:0] wd_sel;

  logic                 en_q;
  logic [ADDR_BITW-1:0] addr_q;
  logic [DATA_BITW-1:0] wd_q;
  logic [BE_W-1:0]      be_q;
  logic [STAGES:0]                 vld_pipe_q;
  logic [STAGES:0][IDX_W-1:0]      tag_pipe_q;
  logic [N_CHAN-1:0]    rvld_q;
  logic [DATA_BITW-1:0] rd_q;

  // First requester at or after the pointer wins; gated so nothing is granted in reset.
  always_comb begin
    gnt   = '0;
    c_idx = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      c_idx = IDX_W'((32'(rr_q) + i) % N_CHAN);
      if (Rst_RBI && gnt == '0 && Req_SI[c_idx]) gnt[c_idx] = 1'b1;
    end
  end

  always_comb begin
    sel      = '0;
    addr_sel = '0;
    be_sel   = '0;
    wd_sel   = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (gnt[i]) begin
        sel      = IDX_W'(i);
        addr_sel = Addr_DI[i*ADDR_BITW +: ADDR_BITW];
        be_sel   = WrEn_SI[i*BE_W +: BE_W];
        wd_sel   = Wr_DI[i*DATA_BITW +: DATA_BITW];
      end
    end
  end

  assign acc  = |(gnt & Req_SI);
  assign rr_d = !acc ? rr_q : (sel == IDX_W'(N_CHAN - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      rr_q       <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      be_q       <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      rvld_q     <= '0;
      rd_q       <= '0;
    end else begin
      rr_q <= rr_d;
      en_q <= acc;
      be_q <= acc ? be_sel : '0;
      if (acc) begin
        addr_q <= addr_sel & ~ADDR_BITW'(BE_W - 1);
        wd_q   <= wd_sel;
      end
      // Stage STAGES lines up with Bram_Rd_DI for the access it tags.
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], acc && be_sel == '0};
      tag_pipe_q <= {tag_pipe_q[STAGES-1:0], sel};
      rvld_q     <= '0;
      if (vld_pipe_q[STAGES]) begin
        rvld_q <= N_CHAN'(1) << tag_pipe_q[STAGES];
        rd_q   <= Bram_Rd_DI;
      end
    end
  end

  assign Gnt_SO       = gnt;
  assign Bram_En_SO   = en_q;
  assign Bram_Addr_SO = addr_q;
  assign Bram_Wr_DO   = wd_q;
  assign Bram_WrEn_SO = be_q;
  assign RdValid_SO   = rvld_q;
  assign Rd_DO        = rd_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench: a reference model predicts grants, BRAM issues and read responses;
// a negedge monitor compares them against the DUT and a behavioural BRAM.
module tb_bram_port_arbiter;
  localparam int N = 4, DW = 32, AW = 32, BW = DW / 8, RL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [AW-1:0]   addr_a [N];
  logic [BW-1:0]   be_a   [N];
  logic [DW-1:0]   wd_a   [N];
  logic [N*AW-1:0] addr_p;
  logic [N*BW-1:0] be_p;
  logic [N*DW-1:0] wd_p;

  logic [N-1:0]  gnt, rvld;
  logic [DW-1:0] rd, bwd, brd;
  logic [AW-1:0] baddr;
  logic [BW-1:0] bbe;
  logic          ben;

  always_comb begin
    addr_p = '0;
    be_p   = '0;
    wd_p   = '0;
    for (int i = 0; i < N; i++) begin
      addr_p[i*AW +: AW] = addr_a[i];
      be_p[i*BW +: BW]   = be_a[i];
      wd_p[i*DW +: DW]   = wd_a[i];
    end
  end

  bram_port_arbiter #(.N_CHAN(N), .DATA_BITW(DW), .ADDR_BITW(AW), .RD_LATENCY(RL)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Gnt_SO(gnt),
    .Addr_DI(addr_p), .WrEn_SI(be_p), .Wr_DI(wd_p),
    .RdValid_SO(rvld), .Rd_DO(rd),
    .Bram_En_SO(ben), .Bram_Addr_SO(baddr), .Bram_Wr_DO(bwd),
    .Bram_WrEn_SO(bbe), .Bram_Rd_DI(brd)
  );

  function automatic logic [DW-1:0] init_word(input int w);
    return DW'(32'hA500_0000 ^ (w * 32'h0001_0203));
  endfunction

  // Behavioural BRAM with RL cycles of read latency after the enable cycle.
  logic [DW-1:0] bmem [int];
  logic [DW-1:0] rdp [RL];
  always @(posedge clk) begin
    int w;
    logic [DW-1:0] cur;
    w   = int'(baddr[7:2]);
    cur = bmem.exists(w) ? bmem[w] : init_word(w);
    if (ben) begin
      for (int b = 0; b < BW; b++) if (bbe[b]) cur[8*b +: 8] = bwd[8*b +: 8];
      if (bbe != '0) bmem[w] = cur;
      rdp[0] <= cur;
    end
    for (int j = 1; j < RL; j++) rdp[j] <= rdp[j-1];
  end
  assign brd = rdp[RL-1];

  typedef struct { int cyc; logic [AW-1:0] a; logic [DW-1:0] d; logic [BW-1:0] be; } iss_t;
  typedef struct { int cyc; int ch; logic [DW-1:0] d; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  int            rr_m = 0;
  logic [DW-1:0] rmem [int];
  logic [DW-1:0] last_rd_m = '0;

  always @(negedge clk) begin
    logic [N-1:0]  eg, ev;
    logic [DW-1:0] cur;
    logic          exp_en;
    int k, w;
    iss_t ie;
    rsp_t re;
    if (!rst_n) begin
      chk("reset_outputs", {gnt, rvld, ben, bbe, |rd, |baddr, |bwd}, '0);
      iss_q.delete();
      rsp_q.delete();
      rr_m      = 0;
      last_rd_m = '0;
    end else begin
      k = -1;
      for (int i = 0; i < N; i++)
        if (k < 0 && req[(rr_m + i) % N]) k = (rr_m + i) % N;
      eg = '0;
      if (k >= 0) eg[k] = 1'b1;
      chk("grant", gnt, eg);

      while (iss_q.size() > 0 && iss_q[0].cyc < cyc) void'(iss_q.pop_front());
      exp_en = iss_q.size() > 0 && iss_q[0].cyc == cyc;
      chk("bram_en", ben, exp_en);
      if (exp_en) begin
        ie = iss_q.pop_front();
        chk("bram_addr", baddr, ie.a);
        chk("bram_wdata", bwd, ie.d);
        chk("bram_wren", bbe, ie.be);
      end else begin
        chk("idle_wren", bbe, '0);
      end

      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) void'(rsp_q.pop_front());
      ev = '0;
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) ev[rsp_q[0].ch] = 1'b1;
      chk("rd_valid", rvld, ev);
      if (ev != '0) begin
        re = rsp_q.pop_front();
        last_rd_m = re.d;
        chk("rd_data", rd, re.d);
      end else begin
        chk("rd_hold", rd, last_rd_m);
      end

      if (k >= 0) begin
        w   = int'(addr_a[k][7:2]);
        cur = rmem.exists(w) ? rmem[w] : init_word(w);
        iss_q.push_back('{cyc + 1, addr_a[k] & ~AW'(BW - 1), wd_a[k], be_a[k]});
        if (be_a[k] == '0) begin
          rsp_q.push_back('{cyc + 2 + RL, k, cur});
        end else begin
          for (int b = 0; b < BW; b++) if (be_a[k][b]) cur[8*b +: 8] = wd_a[k][8*b +: 8];
          rmem[w] = cur;
        end
        rr_m = (k + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic [DW-1:0] d);
    req[c]    = 1'b1;
    addr_a[c] = a;
    be_a[c]   = b;
    wd_a[c]   = d;
  endtask

  initial begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0;
      be_a[i]   = '0;
      wd_a[i]   = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // All channels read continuously straight out of reset.
    for (int c = 0; c < N; c++) set_ch(c, AW'(16 * c + 4), '0, '0);
    repeat (8) step();
    req = '0;
    repeat (2) step();

    set_ch(0, 32'h10, '0, '0);
    step();
    req = '0;
    repeat (RL + 3) step();

    // Partial byte write followed by read-back on the same channel.
    set_ch(2, 32'h20, 4'b0101, 32'hAABBCCDD);
    step();
    req = '0;
    set_ch(2, 32'h20, '0, '0);
    step();
    req = '0;
    repeat (RL + 3) step();

    set_ch(1, 32'h23, '0, '0);
    step();
    req = '0;
    repeat (RL + 3) step();

    for (int i = 0; i < 10; i++) begin
      req = '0;
      set_ch((i % 2) ? 3 : 1, AW'($urandom_range(0, 255)), '0, '0);
      step();
    end
    req = '0;
    repeat (RL + 3) step();

    // Two reads in flight, then reset while their tags are still in the pipeline.
    set_ch(0, 32'h40, '0, '0);
    step();
    req = '0;
    set_ch(3, 32'h44, '0, '0);
    step();
    req = '0;
    step();
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) set_ch(c, AW'(8 * c), '0, '0);
    repeat (2) step();
    req = '0;
    repeat (RL + 3) step();

    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < N; c++) begin
        req[c]    = ($urandom_range(0, 9) < 6);
        addr_a[c] = AW'($urandom_range(0, 255));
        be_a[c]   = ($urandom_range(0, 1) == 1) ? '0 : BW'($urandom);
        wd_a[c]   = $urandom;
      end
      step();
    end
    req = '0;
    repeat (RL + 6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
